// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor and related clock checkers.
package clk_div_mon_pkg;

  localparam int ERR_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    LOCKED,
    FAULT
  } mon_state_e;

  // A period is good when its length matches the ratio and the duty is within half a cycle of 50%.
  function automatic logic is_good_period(input int period, input int high, input int dividor);
    return (period == dividor) && (high >= dividor / 2) && (high <= (dividor + 1) / 2);
  endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Two-flop sampler of a same-domain clock-like signal with a rising-edge strobe.
module clk_edge_det (
  input  logic clk_in,
  input  logic rst,
  input  logic sig,
  output logic sampled,
  output logic rise
);

  logic s0_reg;
  logic s1_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s0_reg <= 1'b0;
      s1_reg <= 1'b0;
    end else begin
      s0_reg <= sig;
      s1_reg <= s0_reg;
    end
  end

  assign sampled = s0_reg;
  assign rise    = s0_reg & ~s1_reg;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock, tracks lock, and flags stuck or wrong-ratio output.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int DIVIDOR   = 5,
  parameter int LOCK_CNT  = 4,
  parameter int TIMEOUT   = 2 * DIVIDOR,
  parameter int CNT_WIDTH = $clog2(TIMEOUT + 1),
  parameter int ERR_WIDTH = ERR_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 div_clk,
  output logic                 period_valid,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 locked,
  output logic                 fault,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_WIDTH-1:0] TMO    = CNT_WIDTH'(TIMEOUT);
  localparam logic [GW-1:0]        LOCK_N = GW'(LOCK_CNT);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  logic s0;
  logic rise;

  clk_edge_det u_edge (
    .clk_in  (clk_in),
    .rst     (rst),
    .sig     (div_clk),
    .sampled (s0),
    .rise    (rise)
  );

  mon_state_e state_reg, state_next;
  logic [CNT_WIDTH-1:0] pcnt_reg, pcnt_next;
  logic [CNT_WIDTH-1:0] hcnt_reg, hcnt_next;
  logic [CNT_WIDTH-1:0] period_reg, period_next;
  logic [CNT_WIDTH-1:0] high_reg, high_next;
  logic [GW-1:0]        good_reg, good_next;
  logic [ERR_WIDTH-1:0] err_reg, err_next;
  logic                 tmo_seen_reg, tmo_seen_next;
  logic                 pv_reg, pv_next;
  logic                 timeout;
  logic                 good_p;
  logic                 meas;
  logic                 err_inc;

  // Timeout fires only on the first saturated cycle of a stuck episode.
  assign timeout = (pcnt_reg == TMO) && !rise && !tmo_seen_reg;
  assign good_p  = is_good_period(32'(pcnt_reg), 32'(hcnt_reg), DIVIDOR);

  always_comb begin
    pcnt_next     = pcnt_reg;
    hcnt_next     = hcnt_reg;
    tmo_seen_next = tmo_seen_reg;
    if (!en) begin
      pcnt_next     = '0;
      hcnt_next     = '0;
      tmo_seen_next = 1'b0;
    end else if (rise) begin
      pcnt_next     = CNT_WIDTH'(1);
      hcnt_next     = CNT_WIDTH'(1);
      tmo_seen_next = 1'b0;
    end else begin
      pcnt_next     = (pcnt_reg == TMO) ? TMO : pcnt_reg + 1'b1;
      hcnt_next     = (hcnt_reg == TMO) ? TMO : hcnt_reg + CNT_WIDTH'(s0);
      tmo_seen_next = tmo_seen_reg | timeout;
    end
  end

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    meas       = 1'b0;
    err_inc    = 1'b0;
    if (!en) begin
      state_next = IDLE;
      good_next  = '0;
    end else begin
      case (state_reg)
        IDLE:    state_next = ACQUIRE;
        ACQUIRE: if (rise) state_next = MEASURE;
        MEASURE: begin
          if (rise) begin
            meas = 1'b1;
            if (good_p) begin
              good_next = good_reg + 1'b1;
              if (good_reg + 1'b1 == LOCK_N) state_next = LOCKED;
            end else begin
              good_next = '0;
              err_inc   = 1'b1;
            end
          end else if (timeout) begin
            good_next  = '0;
            err_inc    = 1'b1;
            state_next = ACQUIRE;
          end
        end
        LOCKED: begin
          if (rise) begin
            meas = 1'b1;
            if (!good_p) begin
              err_inc    = 1'b1;
              state_next = FAULT;
            end
          end else if (timeout) begin
            err_inc    = 1'b1;
            state_next = FAULT;
          end
        end
        FAULT: begin
          if (rise) begin
            meas    = 1'b1;
            err_inc = !good_p;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    pv_next     = meas;
    period_next = meas ? pcnt_reg : period_reg;
    high_next   = meas ? hcnt_reg : high_reg;
    err_next    = (err_inc && err_reg != ERR_MAX) ? err_reg + 1'b1 : err_reg;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg    <= IDLE;
      pcnt_reg     <= '0;
      hcnt_reg     <= '0;
      period_reg   <= '0;
      high_reg     <= '0;
      good_reg     <= '0;
      err_reg      <= '0;
      tmo_seen_reg <= 1'b0;
      pv_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pcnt_reg     <= pcnt_next;
      hcnt_reg     <= hcnt_next;
      period_reg   <= period_next;
      high_reg     <= high_next;
      good_reg     <= good_next;
      err_reg      <= err_next;
      tmo_seen_reg <= tmo_seen_next;
      pv_reg       <= pv_next;
    end
  end

  assign period_valid = pv_reg;
  assign period       = period_reg;
  assign high_time    = high_reg;
  assign locked       = (state_reg == LOCKED);
  assign fault        = (state_reg == FAULT);
  assign err_cnt      = err_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed and randomized checks of clk_div_monitor against a waveform-history reference model.
module tb_clk_div_monitor;

  localparam int DIV  = 5;
  localparam int T    = 10;
  localparam int LOCK = 4;
  localparam int MAXC = 8192;
  localparam int M_IDLE = 0, M_ACQ = 1, M_MEAS = 2, M_LOCKED = 3, M_FAULT = 4;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       div_clk = 1'b0;
  logic       period_valid;
  logic [3:0] period;
  logic [3:0] high_time;
  logic       locked;
  logic       fault;
  logic [7:0] err_cnt;

  clk_div_monitor dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .en           (en),
    .div_clk      (div_clk),
    .period_valid (period_valid),
    .period       (period),
    .high_time    (high_time),
    .locked       (locked),
    .fault        (fault),
    .err_cnt      (err_cnt)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passes = 0;

  // Reference: sampled waveform history plus prefix sums; periods come from rise-to-rise distances.
  bit d_eff[MAXC];
  int cum[MAXC+1];
  int e = 0;
  int ref_e = 0;
  int m_state = M_IDLE;
  int m_good = 0;
  int m_err = 0;
  int m_period = 0;
  int m_high = 0;
  bit m_pv = 0;

  function automatic bit dv(input int i);
    return (i < 0) ? 1'b0 : d_eff[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, act, exp, e);
  endtask

  task automatic model_edge(input bit r, input bit en_v, input bit dc);
    bit rise, good, tmo;
    int since, per, hi;
    if (e >= MAXC - 2) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", e, MAXC - 2);
      $fatal(1, "cycle budget exceeded");
    end
    d_eff[e] = r ? 1'b0 : dc;
    cum[e+1] = cum[e] + int'(d_eff[e]);
    m_pv = 1'b0;
    if (r) begin
      m_state = M_IDLE; m_good = 0; m_err = 0; m_period = 0; m_high = 0; ref_e = e;
    end else if (!en_v) begin
      m_state = M_IDLE; m_good = 0; ref_e = e;
    end else begin
      rise  = dv(e - 1) && !dv(e - 2);
      since = e - 1 - ref_e;
      per   = (since > T) ? T : since;
      hi    = cum[e-1] - cum[ref_e];
      if (hi > T) hi = T;
      good  = (per == DIV) && (hi >= DIV / 2) && (hi <= (DIV + 1) / 2);
      tmo   = !rise && (since == T);
      if (rise && m_state >= M_MEAS) begin
        m_pv = 1'b1; m_period = per; m_high = hi;
      end
      case (m_state)
        M_IDLE: m_state = M_ACQ;
        M_ACQ:  if (rise) m_state = M_MEAS;
        M_MEAS: begin
          if (rise && good) begin
            m_good++;
            if (m_good == LOCK) m_state = M_LOCKED;
          end else if (rise || tmo) begin
            m_good = 0;
            if (m_err < 255) m_err++;
            if (tmo) m_state = M_ACQ;
          end
        end
        M_LOCKED: if ((rise && !good) || tmo) begin
          m_state = M_FAULT;
          if (m_err < 255) m_err++;
        end
        default: if (rise && !good && m_err < 255) m_err++;
      endcase
      if (rise) ref_e = e - 1;
    end
    e++;
  endtask

  task automatic step(input bit r, input bit en_v, input bit dc);
    @(negedge clk_in);
    rst = r; en = en_v; div_clk = dc;
    @(posedge clk_in);
    model_edge(r, en_v, dc);
    #1;
    chk("period_valid", period_valid, m_pv);
    chk("period", period, m_period);
    chk("high_time", high_time, m_high);
    chk("locked", locked, m_state == M_LOCKED);
    chk("fault", fault, m_state == M_FAULT);
    chk("err_cnt", err_cnt, m_err);
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < per; c++) step(1'b0, 1'b1, c < hi);
  endtask

  task automatic hold(input int n, input bit en_v, input bit dc);
    for (int c = 0; c < n; c++) step(1'b0, en_v, dc);
  endtask

  task automatic show(input string name);
    $display("%s: period=%0d high=%0d locked=%0b fault=%0b err=%0d", name, period, high_time,
             locked, fault, err_cnt);
  endtask

  initial begin
    cum[0] = 0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_period_valid", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_cnt, 0);
    show("reset");

    hold(3, 1'b1, 1'b0);
    wave(5, 3, 7);
    chk("nominal_locked", locked, 1);
    chk("nominal_period", period, 5);
    chk("nominal_high", high_time, 3);
    chk("nominal_err", err_cnt, 0);
    show("nominal");

    hold(15, 1'b1, 1'b0);
    chk("stuck_fault", fault, 1);
    chk("stuck_locked", locked, 0);
    chk("stuck_err", err_cnt, 1);
    show("stuck_low");

    wave(7, 3, 2);
    chk("fault_err3", err_cnt, 3);
    step(1'b0, 1'b0, 1'b0);
    chk("en_clear_fault", fault, 0);
    chk("en_clear_err", err_cnt, 3);
    show("enable_clear");
    hold(2, 1'b1, 1'b0);
    wave(5, 3, 7);
    chk("relock", locked, 1);
    show("relock");

    step(1'b0, 1'b0, 1'b0);
    wave(5, 1, 6);
    chk("duty_high", high_time, 1);
    chk("duty_nolock", locked, 0);
    show("duty_error");
    wave(5, 3, 6);
    chk("duty_restore_lock", locked, 1);
    show("duty_restore");

    step(1'b0, 1'b0, 1'b0);
    wave(7, 3, 260);
    chk("ratio_err_sat", err_cnt, 255);
    chk("ratio_period", period, 7);
    chk("ratio_nolock", locked, 0);
    show("wrong_ratio");

    step(1'b0, 1'b0, 1'b0);
    wave(5, 3, 7);
    chk("pre_reset_locked", locked, 1);
    step(1'b1, 1'b1, 1'b0);
    chk("midrst_locked", locked, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_period", period, 0);
    chk("midrst_high", high_time, 0);
    show("reset_mid_run");
    wave(5, 3, 7);
    chk("post_reset_lock", locked, 1);
    show("post_reset_relock");

    for (int k = 0; k < 120; k++) begin
      int per, hi;
      per = int'($urandom_range(3, 12));
      hi  = int'($urandom_range(1, per - 1));
      if ($urandom_range(0, 2) == 0) begin
        per = 5;
        hi  = 2 + int'($urandom_range(0, 1));
      end
      wave(per, hi, int'($urandom_range(1, 5)));
      if ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 14) == 0) hold(12, 1'b1, 1'b0);
      if ($urandom_range(0, 29) == 0) step(1'b1, 1'b1, 1'b0);
    end
    show("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Downstream checker for the odd-ratio clock divider. It samples the divided clock in the source clock domain and measures each period and its high time in source-clock cycles. It declares lock after a run of correct periods, and flags stuck or wrong-ratio output. It feeds status to the clock-control logic and the bench scoreboard.

Parameters:
DIVIDOR, 5, expected divide ratio; odd, >= 3.
LOCK_CNT, 4, consecutive good periods required to lock.
TIMEOUT, 2*DIVIDOR, cycles without a rising edge before a stuck event.
CNT_WIDTH, $clog2(TIMEOUT+1), width of the period and high-time counters.
ERR_WIDTH, 8, width of the saturating error counter.

Ports:
clk_in  input  1  source clock; single clock domain.
rst  input  1  synchronous, active-high reset.
en  input  1  monitor enable; low forces IDLE.
div_clk  input  1  divided clock from the divider, generated synchronously from clk_in, so no synchronizer.
period_valid  output  1  one-cycle pulse: period and high_time updated.
period  output  CNT_WIDTH  last measured period in clk_in cycles.
high_time  output  CNT_WIDTH  sampled-high cycles within the last period.
locked  output  1  in LOCKED state.
fault  output  1  in FAULT state.
err_cnt  output  ERR_WIDTH  saturating count of bad periods and timeouts.

Behaviour:
- Reset (rst=1 at a clk_in edge): state IDLE; all outputs 0; s0, s1, pcnt, hcnt, good_cnt cleared. Reset mid-operation behaves identically.
- Sampling: s0 <= div_clk; s1 <= s0; rise = s0 & ~s1 (combinational).
- pcnt: on rise, pcnt <= 1; otherwise pcnt <= pcnt+1, saturating at TIMEOUT.
- hcnt: on rise, hcnt <= 1; otherwise hcnt <= hcnt + s0, saturating.
- Measurement on a rise (states MEASURE or LOCKED):
  - Register period <= pcnt and high_time <= hcnt (pre-update values); pulse period_valid for 1 cycle.
  - Latency: outputs change one clk_in edge after the edge where s0 first captures 1.
- Good period: period == DIVIDOR and high_time in [DIVIDOR/2, (DIVIDOR+1)/2], i.e. 2..3 for DIVIDOR=5.
- Timeout event: pcnt == TIMEOUT and no rise in that cycle; fires once per stuck episode.
- FSM (registered; locked and fault decoded from state):
  - IDLE: en=1 -> ACQUIRE.
  - ACQUIRE: first rise -> MEASURE. No measurement is reported on this rise.
  - MEASURE:
    - good period -> good_cnt+1; when good_cnt reaches LOCK_CNT -> LOCKED.
    - bad period -> good_cnt <= 0, err_cnt+1, stay.
    - timeout -> good_cnt <= 0, err_cnt+1, -> ACQUIRE.
  - LOCKED: bad period or timeout -> FAULT, err_cnt+1.
  - FAULT: sticky. Measurements continue and each bad period increments err_cnt. Exit only via en=0 or rst.
  - Any state with en=0 -> IDLE next cycle: locked and fault drop; pcnt, hcnt and good_cnt cleared; err_cnt retained.
- err_cnt saturates at 2^ERR_WIDTH-1 and never wraps. A bad period and a timeout in the same cycle are impossible, because a rise blocks the timeout.
- Simultaneous en falling and a rise: en wins; no measurement is reported.

Decomposition:
- Package clk_div_mon_pkg:
  - state enum: IDLE, ACQUIRE, MEASURE, LOCKED, FAULT.
  - ERR_WIDTH default.
  - function is_good_period(period, high, dividor).
- Sub-module clk_edge_det: the s0/s1 flops and the rise output. Reused by other clock checkers.

Test Plan:
1. Nominal: instantiate the divider with dividor=5, en=1 after reset -> period_valid every 5 cycles, period=5, high_time in {2,3} and constant, locked=1 after the 4th period_valid, fault=0, err_cnt=0.
2. Stuck low: force div_clk=0 while LOCKED -> fault=1 when pcnt reaches 10 (10 cycles after the last rise), locked=0, err_cnt=1, no period_valid.
3. Wrong ratio: drive div_clk with period 7 (high 3) -> never locked, period=7 on each pulse, err_cnt increments per period and holds at 255 after 255 periods.
4. Duty error: period 5 with high 1 cycle -> high_time=1, no lock, err_cnt increments each period; restore 5/3 -> locked after 4 good periods.
5. Enable clear: in FAULT with err_cnt=3, en=0 for 1 cycle -> IDLE next cycle, fault=0, err_cnt=3; en=1 with nominal div_clk -> relock after first rise plus 4 periods.
6. Reset mid-run: rst=1 for one cycle while LOCKED -> next cycle all outputs 0, including err_cnt; relock sequence as in test 1.
